// File: rtl/axi4_rd_arbiter.sv
// Two-master round-robin arbiter for the AXI4 AR/R path; optional watchdog under `ARB_WDOG_EN`.
// Latency: 1 IDLE arbitration cycle, then AR and R pass through combinationally.
// Backpressure: the non-granted master sees arready=0; R ready follows the granted master.
module axi4_rd_arbiter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BUS_LEN_WIDTH = 5,
  parameter int ID_WIDTH      = 4,
  parameter int WDOG_CYCLES   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 m_arvalid,
  output logic [1:0]                 m_arready,
  input  logic [2*ADDR_WIDTH-1:0]    m_araddr,
  input  logic [2*BUS_LEN_WIDTH-1:0] m_arlen,
  input  logic [2*ID_WIDTH-1:0]      m_arid,
  input  logic [5:0]                 m_arsize,
  input  logic [3:0]                 m_arburst,
  output logic [1:0]                 m_rvalid,
  input  logic [1:0]                 m_rready,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic                       m_rlast,
  output logic [1:0]                 m_rresp,
  output logic [ID_WIDTH-1:0]        m_rid,
  output logic                       s_arvalid,
  input  logic                       s_arready,
  output logic [ADDR_WIDTH-1:0]      s_araddr,
  output logic [BUS_LEN_WIDTH-1:0]   s_arlen,
  output logic [ID_WIDTH-1:0]        s_arid,
  output logic [2:0]                 s_arsize,
  output logic [1:0]                 s_arburst,
  input  logic                       s_rvalid,
  output logic                       s_rready,
  input  logic [DATA_WIDTH-1:0]      s_rdata,
  input  logic                       s_rlast,
  input  logic [1:0]                 s_rresp,
  input  logic [ID_WIDTH-1:0]        s_rid,
  output logic                       busy,
  output logic                       wdog_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last_grant, last_grant_nxt;
  logic   timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

`ifdef ARB_WDOG_EN
  logic [15:0] wdog_cnt;
  logic        wdog_err_q;

  // Held at zero while IDLE, so every burst starts counting from ADDR entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt   <= '0;
      wdog_err_q <= 1'b0;
    end else if (state == IDLE) begin
      wdog_cnt   <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + 16'd1;
      if (timeout) wdog_err_q <= 1'b1;
    end
  end

  assign timeout  = (state != IDLE) && (wdog_cnt == 16'(WDOG_CYCLES - 1));
  assign wdog_err = wdog_err_q;
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES == 0);
  assign timeout     = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    m_arready      = 2'b00;
    m_rvalid       = 2'b00;
    s_arvalid      = 1'b0;
    s_rready       = 1'b0;
    case (state)
      IDLE: begin
        if (|m_arvalid) begin
          grant_nxt = (m_arvalid == 2'b11) ? ~last_grant : m_arvalid[1];
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        s_arvalid        = m_arvalid[grant];
        m_arready[grant] = s_arready;
        if (s_arvalid && s_arready) state_nxt = DATA;
      end
      DATA: begin
        m_rvalid[grant] = s_rvalid;
        s_rready        = m_rready[grant];
        if (s_rvalid && s_rready && s_rlast) begin
          last_grant_nxt = grant;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A stalled burst is abandoned and the other master gets priority next.
    if (timeout) begin
      state_nxt      = IDLE;
      last_grant_nxt = grant;
    end
    if (rst) begin
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
    end
  end

  assign s_araddr  = grant ? m_araddr[ADDR_WIDTH +: ADDR_WIDTH]       : m_araddr[0 +: ADDR_WIDTH];
  assign s_arlen   = grant ? m_arlen[BUS_LEN_WIDTH +: BUS_LEN_WIDTH]  : m_arlen[0 +: BUS_LEN_WIDTH];
  assign s_arid    = grant ? m_arid[ID_WIDTH +: ID_WIDTH]             : m_arid[0 +: ID_WIDTH];
  assign s_arsize  = grant ? m_arsize[5:3]  : m_arsize[2:0];
  assign s_arburst = grant ? m_arburst[3:2] : m_arburst[1:0];

  assign m_rdata = s_rdata;
  assign m_rlast = s_rlast;
  assign m_rresp = s_rresp;
  assign m_rid   = s_rid;

  assign busy = (state != IDLE) && !rst;

endmodule
